audio_out_sequencer: RTL

//  Power/mute sequencer for the S/PDIF -> I2S output path. Watches decoder

---
 rtl/toi2s_pkg.sv | 21 ++
 rtl/audio_out_sequencer_watchdog.sv | 30 +++
 rtl/audio_out_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/toi2s_pkg.sv
// Shared definitions for the S/PDIF -> I2S output path: FSM state codes and
// default sequencing times for the amp/DAC power/mute sequencer.
package toi2s_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_QUALIFY  = 3'd1,
        ST_POWERUP  = 3'd2,
        ST_PLAY     = 3'd3,
        ST_SHUTDOWN = 3'd4
    } state_t;

    localparam int unsigned DEF_LOCK_HOLD   = 65536;
    localparam int unsigned DEF_SETTLE      = 262144;
    localparam int unsigned DEF_MUTE_HOLD   = 4096;
    localparam int unsigned DEF_ACT_TIMEOUT = 1024;
    localparam int unsigned DEF_CNT_W       = 20;

    localparam logic [7:0]  DROP_MAX        = 8'hFF;

endpackage

// File: rtl/audio_out_sequencer_watchdog.sv
// Line-activity watchdog: reports loss of signal once ACT_TIMEOUT cycles pass
// without an S/PDIF transition. Comes out of reset in the "no activity" state.
module activity_watchdog #(
    parameter int unsigned ACT_TIMEOUT = 1024,
    parameter int unsigned WIDTH       = $clog2(ACT_TIMEOUT + 1)
) (
    input  logic clk_in,
    input  logic reset,
    input  logic edgedetect,
    output logic act_ok
);

    localparam logic [WIDTH-1:0] LP_SAT = WIDTH'(ACT_TIMEOUT);

    logic [WIDTH-1:0] r_act_cnt;

    // Cycles since the last line transition, saturating at the timeout.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_act_cnt <= LP_SAT;
        end else if (edgedetect) begin
            r_act_cnt <= '0;
        end else if (r_act_cnt != LP_SAT) begin
            r_act_cnt <= r_act_cnt + 1'b1;
        end
    end

    assign act_ok = (r_act_cnt < LP_SAT);

endmodule

// File: rtl/audio_out_sequencer.sv
// Pop-free power/mute sequencer for the external amp/DAC. Enables the analog
// stage before unmuting and mutes it before disabling, driven by decoder lock
// and line activity.
module audio_out_sequencer
    import toi2s_pkg::*;
#(
    parameter int unsigned LOCK_HOLD   = DEF_LOCK_HOLD,
    parameter int unsigned SETTLE      = DEF_SETTLE,
    parameter int unsigned MUTE_HOLD   = DEF_MUTE_HOLD,
    parameter int unsigned ACT_TIMEOUT = DEF_ACT_TIMEOUT,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       audio_locked,
    input  logic       edgedetect,
    input  logic       force_mute,
    output logic       nenable_out,
    output logic       nmute_out,
    output logic [2:0] state_out,
    output logic [7:0] drop_count
);

    localparam logic [CNT_W-1:0] LP_LOCK_END   = CNT_W'(LOCK_HOLD - 1);
    localparam logic [CNT_W-1:0] LP_SETTLE_END = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] LP_MUTE_END   = CNT_W'(MUTE_HOLD - 1);

    logic             w_act_ok;
    logic             w_good;
    logic             w_drop_evt;
    logic             w_nen_d;
    logic             w_nmute_d;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_nen;
    logic             r_nmute;
    logic [7:0]       r_drops;

    activity_watchdog #(
        .ACT_TIMEOUT (ACT_TIMEOUT)
    ) u_watchdog (
        .clk_in     (clk_in),
        .reset      (reset),
        .edgedetect (edgedetect),
        .act_ok     (w_act_ok)
    );

    assign w_good     = audio_locked & w_act_ok;
    assign w_drop_evt = (r_state == ST_PLAY) & ~w_good;

    // State register and phase timer; the timer restarts on every state change.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
        end
    end

    // Next-state logic; loss of "good" wins over timer expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_OFF: begin
                if (w_good) w_next = ST_QUALIFY;
            end
            ST_QUALIFY: begin
                if (!w_good)                   w_next = ST_OFF;
                else if (r_cnt == LP_LOCK_END) w_next = ST_POWERUP;
            end
            ST_POWERUP: begin
                if (!w_good)                     w_next = ST_SHUTDOWN;
                else if (r_cnt == LP_SETTLE_END) w_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (!w_good) w_next = ST_SHUTDOWN;
            end
            ST_SHUTDOWN: begin
                if (r_cnt == LP_MUTE_END) w_next = ST_OFF;
            end
            default: w_next = ST_SHUTDOWN;
        endcase
    end

    // Pin decode of the upcoming state, so registered pins track the state register.
    always_comb begin
        w_nen_d   = 1'b1;
        w_nmute_d = 1'b0;
        case (w_next)
            ST_POWERUP, ST_SHUTDOWN: w_nen_d = 1'b0;
            ST_PLAY: begin
                w_nen_d   = 1'b0;
                w_nmute_d = ~force_mute;
            end
            default: begin
                w_nen_d   = 1'b1;
                w_nmute_d = 1'b0;
            end
        endcase
    end

    // Registered amp pins; reset forces disabled and muted at once.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_nen   <= 1'b1;
            r_nmute <= 1'b0;
        end else begin
            r_nen   <= w_nen_d;
            r_nmute <= w_nmute_d;
        end
    end

    // Saturating count of signal drops while playing.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_drops <= '0;
        end else if (w_drop_evt && (r_drops != DROP_MAX)) begin
            r_drops <= r_drops + 1'b1;
        end
    end

    assign nenable_out = r_nen;
    assign nmute_out   = r_nmute;
    assign state_out   = r_state;
    assign drop_count  = r_drops;

endmodule
